// File: rtl/k7_aurora_link_supervisor.sv
// k7_aurora_link_supervisor
// Sequences the Kintex-7 Aurora reset pins (PMA_INIT, then RESET_PB) and waits
// for CHANNEL_UP. Timeouts are counted and the block gives up after MAX_RETRY
// consecutive timeouts. A live link is torn down on channel loss or hard error
// (full PMA reset) or on too many soft errors within a window (PB reset only).
// One 24-bit timer is shared by every state and restarts on each state entry.
// In UP the same timer also measures the soft-error window.
module k7_aurora_link_supervisor #(
  parameter int PMA_HOLD    = 100,
  parameter int PB_HOLD     = 100,
  parameter int TIMEOUT     = 5000000,
  parameter int MAX_RETRY   = 8,
  parameter int SOFT_LIMIT  = 8,
  parameter int SOFT_WINDOW = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CHANNEL_UP,
  input  logic       HARD_ERR,
  input  logic       SOFT_ERR,
  input  logic       CLEAR,
  output logic       PMA_INIT,
  output logic       RESET_PB,
  output logic       LINK_OK,
  output logic       FAIL,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] DROP_CNT
);

  localparam int SW = $clog2(SOFT_LIMIT + 1);

  // Terminal timer values: a state with hold N lasts exactly N cycles.
  localparam logic [23:0]   PMA_LAST  = 24'(PMA_HOLD - 1);
  localparam logic [23:0]   PB_LAST   = 24'(PB_HOLD - 1);
  localparam logic [23:0]   TO_LAST   = 24'(TIMEOUT - 1);
  localparam logic [23:0]   WIN_LAST  = 24'(SOFT_WINDOW - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [SW-1:0] SOFT_LAST = SW'(SOFT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_PMA    = 3'd0,
    S_PB     = 3'd1,
    S_WAIT   = 3'd2,
    S_UP     = 3'd3,
    S_FAILED = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [23:0]     timer_q, timer_d;
  logic [SW-1:0]   soft_q, soft_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      drop_q, drop_d;
  logic            pma_q, pma_d;
  logic            pb_q, pb_d;
  logic            ok_q, ok_d;
  logic            fail_q, fail_d;
  logic            drop_inc;
  logic [3:0]      retry_inc;

  assign retry_inc = retry_q + 4'd1;

  // State, counters and registered outputs; reset restarts from a full PMA hold.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_PMA;
      timer_q <= '0;
      soft_q  <= '0;
      retry_q <= '0;
      drop_q  <= '0;
      pma_q   <= 1'b1;
      pb_q    <= 1'b1;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      soft_q  <= soft_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
      pma_q   <= pma_d;
      pb_q    <= pb_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state decode; outputs are decoded from the next state so that the
  // registered pins line up with the registered state.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 24'd1;
    soft_d   = '0;
    retry_d  = retry_q;
    drop_d   = drop_q;
    drop_inc = 1'b0;

    case (state_q)
      S_PMA: begin
        if (timer_q == PMA_LAST) state_d = S_PB;
      end
      S_PB: begin
        if (timer_q == PB_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Channel up wins over a timeout landing in the same cycle.
        if (CHANNEL_UP) begin
          state_d = S_UP;
          retry_d = '0;
        end else if (timer_q == TO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? S_FAILED : S_PMA;
        end
      end
      S_UP: begin
        // Hard causes take priority and cost a single drop count.
        if (!CHANNEL_UP || HARD_ERR) begin
          state_d  = S_PMA;
          drop_inc = 1'b1;
        end else if (SOFT_ERR && (soft_q == SOFT_LAST)) begin
          state_d  = S_PB;
          drop_inc = 1'b1;
        end else if (timer_q == WIN_LAST) begin
          // Window closes: the soft count and the window timer restart together.
          soft_d  = '0;
          timer_d = '0;
        end else begin
          soft_d = soft_q + SW'(SOFT_ERR);
        end
      end
      S_FAILED: begin
        timer_d = '0;
        if (CLEAR) begin
          state_d = S_PMA;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_PMA;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
      soft_d  = '0;
    end

    if (drop_inc && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    pma_d  = (state_d == S_PMA) || (state_d == S_FAILED);
    pb_d   = (state_d == S_PMA) || (state_d == S_PB) || (state_d == S_FAILED);
    ok_d   = (state_d == S_UP);
    fail_d = (state_d == S_FAILED);
  end

  assign PMA_INIT  = pma_q;
  assign RESET_PB  = pb_q;
  assign LINK_OK   = ok_q;
  assign FAIL      = fail_q;
  assign RETRY_CNT = retry_q;
  assign DROP_CNT  = drop_q;

endmodule
